iot_riscv_decode: RTL and testbench
===================================

Name: iot_riscv_decode

Overview:
- ID pipeline stage of the iot_riscv core; producer of the id_* bundle consumed by the EX-stage ALU.
- Accepts fetched RV32IM instructions over a valid/ready handshake, decodes them and reads operands with EX writeback bypass.
- Registers the full id_* bundle and holds it while EX stalls; flushes on taken branch; injects pending interrupts.

Parameters:
- pc_size_p, 32, width of all PC signals.

Ports:
- main_clk_i  input  1  clock
- main_rst_i  input  1  synchronous reset, active-high
- if_valid_i  input  1  fetch has an instruction
- if_instr_i  input  32  instruction word
- if_pc_i  input  pc_size_p  instruction address
- if_next_pc_i  input  pc_size_p  sequential next address
- if_ready_o  output  1  ID accepts this cycle
- irq_i  input  1  level interrupt request (already masked by CSR logic)
- ex_stall_i  input  1  EX cannot take a new instruction
- branch_taken_i  input  1  EX redirect; flush ID
- rf_ra_idx_o  output  5  combinational rs1 index = if_instr_i[19:15]
- rf_rb_idx_o  output  5  combinational rs2 index = if_instr_i[24:20]
- rf_ra_value_i  input  32  regfile read data for rs1
- rf_rb_value_i  input  32  regfile read data for rs2
- wb_en_i  input  1  writeback valid this cycle
- wb_idx_i  input  5  writeback register
- wb_value_i  input  32  writeback data
- id_valid_o  output  1  id_* bundle valid
- id_rd_idx_o  output  5  destination register (0 = no write)
- id_op_imm_o, id_imm_o(32), id_ra_value_o(32), id_rb_value_o(32), id_alu_op_o(4), id_a_signed_o, id_b_signed_o, id_break_o, id_pc_o(pc_size_p), id_next_pc_o(pc_size_p), id_irq_o, id_mret_o, id_branch_o(3), id_reg_jump_o  outputs  drive the same-named ALU inputs
- id_illegal_o  output  1  undecodable instruction

Behaviour:
- Reset: every output 0; interrupt-pending flag cleared. Reset dominates all other events.
- if_ready_o = !ex_stall_i. Accept = if_valid_i && if_ready_o.
- Bundle register update, in priority order:
  - branch_taken_i: id_valid_o <= 0; any instruction accepted that cycle is discarded.
  - accept: load decoded bundle, id_valid_o <= 1. Latency is 1 cycle from accept to id_valid_o.
  - !ex_stall_i && !accept: id_valid_o <= 0.
  - ex_stall_i: hold the whole bundle unchanged.
- Operand read: value = 0 if idx==0; else wb_value_i if wb_en_i && wb_idx_i==idx; else rf value. Sampled at accept.
- Immediates: I, S, B, U, J formats, sign-extended to 32 bits.
- alu_op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 MUL, 10 MULH, 11 DIV, 12 REM, 13 PASSB (LUI), 14 ADDPC (AUIPC), 15 reserved.
- Signedness flags:
  - SLTU, SLTIU, BLTU, BGEU, DIVU, REMU: a_signed=b_signed=0.
  - MULHSU: a=1, b=0. MULHU: both 0.
  - All other signed operations: both 1.
- id_op_imm_o = 1 for OP-IMM, LOAD, STORE, LUI, AUIPC, JALR.
- branch encoding: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 JAL/JALR. id_reg_jump_o = 1 only for JALR. JAL/JALR use rd_idx = rd and alu_op = ADDPC.
- SYSTEM instructions:
  - EBREAK, ECALL: id_break_o = 1.
  - MRET: id_mret_o = 1.
  - All three: id_rd_idx_o = 0.
- Illegal instruction (unknown opcode/funct, or instr[1:0] != 2'b11):
  - id_illegal_o = 1, id_break_o = 1, rd_idx = 0, branch = 0.
- Interrupt injection:
  - irq_i high sets the pending flag.
  - On the next accept, the bundle carries id_irq_o = 1 with the accepted PC.
  - In that bundle, rd_idx, branch, break, mret and illegal are all forced to 0.
  - The pending flag clears on that accept, unless a flush discards it in the same cycle.
- Same-cycle irq_i and accept: inject into that instruction.

Test Plan:
- Reset, then if_valid_i=1 with instr 0x00500093 (ADDI x1,x0,5) at pc 0x100 -> next cycle: id_valid_o=1, alu_op=0, op_imm=1, imm=5, rd_idx=1, pc=0x100.
- BLTU x2,x3,-4 (0xFE316EE3) with rf values 7 and 9 -> branch=3, a_signed=b_signed=0, imm=0xFFFFFFFC, ra=7, rb=9.
- ex_stall_i held high 3 cycles after a valid bundle -> if_ready_o=0 and bundle unchanged for 3 cycles; a new bundle is loaded the cycle after release.
- branch_taken_i and accept in the same cycle -> id_valid_o=0 next cycle; a subsequent accept loads normally.
- Bypass: wb_en_i=1, wb_idx_i=2, wb_value_i=0xDEADBEEF while accepting ADD x4,x2,x0 with rf value 0 -> id_ra_value_o=0xDEADBEEF; same stimulus with wb_idx_i=0 and rs1=x0 -> 0.
- irq_i pulse, then accept 0x00000013 at pc 0x200 -> id_irq_o=1, rd_idx=0, pc=0x200; next accepted instruction has id_irq_o=0. Instruction 0xFFFFFFFF -> id_illegal_o=1, id_break_o=1.

Source files
------------

// File: rtl/iot_riscv_decode.sv
// rtl/iot_riscv_decode.sv - RV32IM instruction decode stage with operand bypass, stall hold, flush and interrupt injection
module iot_riscv_decode #(
    parameter int pc_size_p = 32
) (
    input  logic                 main_clk_i,
    input  logic                 main_rst_i,
    input  logic                 if_valid_i,
    input  logic [31:0]          if_instr_i,
    input  logic [pc_size_p-1:0] if_pc_i,
    input  logic [pc_size_p-1:0] if_next_pc_i,
    output logic                 if_ready_o,
    input  logic                 irq_i,
    input  logic                 ex_stall_i,
    input  logic                 branch_taken_i,
    output logic [4:0]           rf_ra_idx_o,
    output logic [4:0]           rf_rb_idx_o,
    input  logic [31:0]          rf_ra_value_i,
    input  logic [31:0]          rf_rb_value_i,
    input  logic                 wb_en_i,
    input  logic [4:0]           wb_idx_i,
    input  logic [31:0]          wb_value_i,
    output logic                 id_valid_o,
    output logic [4:0]           id_rd_idx_o,
    output logic                 id_op_imm_o,
    output logic [31:0]          id_imm_o,
    output logic [31:0]          id_ra_value_o,
    output logic [31:0]          id_rb_value_o,
    output logic [3:0]           id_alu_op_o,
    output logic                 id_a_signed_o,
    output logic                 id_b_signed_o,
    output logic                 id_break_o,
    output logic [pc_size_p-1:0] id_pc_o,
    output logic [pc_size_p-1:0] id_next_pc_o,
    output logic                 id_irq_o,
    output logic                 id_mret_o,
    output logic [2:0]           id_branch_o,
    output logic                 id_reg_jump_o,
    output logic                 id_illegal_o
);

    localparam logic [3:0] alu_add   = 4'd0;
    localparam logic [3:0] alu_sub   = 4'd1;
    localparam logic [3:0] alu_and   = 4'd2;
    localparam logic [3:0] alu_or    = 4'd3;
    localparam logic [3:0] alu_xor   = 4'd4;
    localparam logic [3:0] alu_slt   = 4'd5;
    localparam logic [3:0] alu_sll   = 4'd6;
    localparam logic [3:0] alu_srl   = 4'd7;
    localparam logic [3:0] alu_sra   = 4'd8;
    localparam logic [3:0] alu_mul   = 4'd9;
    localparam logic [3:0] alu_mulh  = 4'd10;
    localparam logic [3:0] alu_div   = 4'd11;
    localparam logic [3:0] alu_rem   = 4'd12;
    localparam logic [3:0] alu_passb = 4'd13;
    localparam logic [3:0] alu_addpc = 4'd14;

    localparam logic [2:0] br_none = 3'd0;
    localparam logic [2:0] br_beq  = 3'd1;
    localparam logic [2:0] br_bne  = 3'd2;
    localparam logic [2:0] br_blt  = 3'd3;
    localparam logic [2:0] br_bge  = 3'd4;
    localparam logic [2:0] br_jump = 3'd5;

    logic accept;
    logic irq_pending;
    logic irq_now;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [3:0]  d_alu_op;
    logic        d_op_imm;
    logic        d_a_signed;
    logic        d_b_signed;
    logic        d_break;
    logic        d_mret;
    logic        d_illegal;
    logic        d_reg_jump;
    logic [2:0]  d_branch;
    logic [4:0]  d_rd;
    logic [31:0] d_imm;
    logic [31:0] ra_value;
    logic [31:0] rb_value;

    assign if_ready_o  = !ex_stall_i && !main_rst_i;
    assign accept      = if_valid_i && if_ready_o;
    assign irq_now     = irq_i || irq_pending;
    assign rf_ra_idx_o = if_instr_i[19:15];
    assign rf_rb_idx_o = if_instr_i[24:20];

    assign opcode   = if_instr_i[6:0];
    assign funct3   = if_instr_i[14:12];
    assign funct7   = if_instr_i[31:25];
    assign rd_field = if_instr_i[11:7];

    assign imm_i = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
    assign imm_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
    assign imm_b = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                    if_instr_i[30:25], if_instr_i[11:8], 1'b0};
    assign imm_u = {if_instr_i[31:12], 12'b0};
    assign imm_j = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                    if_instr_i[20], if_instr_i[30:21], 1'b0};

    // Writeback in the same cycle wins over the stale regfile read; x0 is always zero.
    function automatic logic [31:0] read_operand(input logic [4:0]  idx,
                                                 input logic [31:0] rf_value,
                                                 input logic        wen,
                                                 input logic [4:0]  widx,
                                                 input logic [31:0] wvalue);
        if (idx == 5'd0)
            return 32'd0;
        else if (wen && (widx == idx))
            return wvalue;
        else
            return rf_value;
    endfunction

    assign ra_value = read_operand(rf_ra_idx_o, rf_ra_value_i, wb_en_i, wb_idx_i, wb_value_i);
    assign rb_value = read_operand(rf_rb_idx_o, rf_rb_value_i, wb_en_i, wb_idx_i, wb_value_i);

    always_comb begin
        d_alu_op   = alu_add;
        d_op_imm   = 1'b0;
        d_a_signed = 1'b1;
        d_b_signed = 1'b1;
        d_break    = 1'b0;
        d_mret     = 1'b0;
        d_illegal  = 1'b0;
        d_reg_jump = 1'b0;
        d_branch   = br_none;
        d_rd       = rd_field;
        d_imm      = 32'd0;

        case (opcode)
            7'b0110111: begin
                d_alu_op = alu_passb;
                d_op_imm = 1'b1;
                d_imm    = imm_u;
            end
            7'b0010111: begin
                d_alu_op = alu_addpc;
                d_op_imm = 1'b1;
                d_imm    = imm_u;
            end
            7'b1101111: begin
                d_alu_op = alu_addpc;
                d_branch = br_jump;
                d_imm    = imm_j;
            end
            7'b1100111: begin
                d_alu_op   = alu_addpc;
                d_branch   = br_jump;
                d_reg_jump = 1'b1;
                d_op_imm   = 1'b1;
                d_imm      = imm_i;
                if (funct3 != 3'b000) d_illegal = 1'b1;
            end
            7'b1100011: begin
                d_alu_op = alu_sub;
                d_rd     = 5'd0;
                d_imm    = imm_b;
                case (funct3)
                    3'b000: d_branch = br_beq;
                    3'b001: d_branch = br_bne;
                    3'b100: d_branch = br_blt;
                    3'b101: d_branch = br_bge;
                    3'b110: begin
                        d_branch   = br_blt;
                        d_a_signed = 1'b0;
                        d_b_signed = 1'b0;
                    end
                    3'b111: begin
                        d_branch   = br_bge;
                        d_a_signed = 1'b0;
                        d_b_signed = 1'b0;
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                d_op_imm = 1'b1;
                d_imm    = imm_i;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_illegal = 1'b1;
            end
            7'b0100011: begin
                d_op_imm = 1'b1;
                d_rd     = 5'd0;
                d_imm    = imm_s;
                if (funct3 > 3'b010) d_illegal = 1'b1;
            end
            7'b0010011: begin
                d_op_imm = 1'b1;
                d_imm    = imm_i;
                case (funct3)
                    3'b000: d_alu_op = alu_add;
                    3'b010: d_alu_op = alu_slt;
                    3'b011: begin
                        d_alu_op   = alu_slt;
                        d_a_signed = 1'b0;
                        d_b_signed = 1'b0;
                    end
                    3'b100: d_alu_op = alu_xor;
                    3'b110: d_alu_op = alu_or;
                    3'b111: d_alu_op = alu_and;
                    3'b001: begin
                        d_alu_op = alu_sll;
                        if (funct7 != 7'b0000000) d_illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == 7'b0000000)
                            d_alu_op = alu_srl;
                        else if (funct7 == 7'b0100000)
                            d_alu_op = alu_sra;
                        else
                            d_illegal = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: d_alu_op = alu_add;
                        3'b001: d_alu_op = alu_sll;
                        3'b010: d_alu_op = alu_slt;
                        3'b011: begin
                            d_alu_op   = alu_slt;
                            d_a_signed = 1'b0;
                            d_b_signed = 1'b0;
                        end
                        3'b100: d_alu_op = alu_xor;
                        3'b101: d_alu_op = alu_srl;
                        3'b110: d_alu_op = alu_or;
                        default: d_alu_op = alu_and;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)
                        d_alu_op = alu_sub;
                    else if (funct3 == 3'b101)
                        d_alu_op = alu_sra;
                    else
                        d_illegal = 1'b1;
                end else if (funct7 == 7'b0000001) begin
                    case (funct3)
                        3'b000: d_alu_op = alu_mul;
                        3'b001: d_alu_op = alu_mulh;
                        3'b010: begin
                            d_alu_op   = alu_mulh;
                            d_b_signed = 1'b0;
                        end
                        3'b011: begin
                            d_alu_op   = alu_mulh;
                            d_a_signed = 1'b0;
                            d_b_signed = 1'b0;
                        end
                        3'b100: d_alu_op = alu_div;
                        3'b101: begin
                            d_alu_op   = alu_div;
                            d_a_signed = 1'b0;
                            d_b_signed = 1'b0;
                        end
                        3'b110: d_alu_op = alu_rem;
                        default: begin
                            d_alu_op   = alu_rem;
                            d_a_signed = 1'b0;
                            d_b_signed = 1'b0;
                        end
                    endcase
                end else begin
                    d_illegal = 1'b1;
                end
            end
            7'b0001111: begin
                d_rd = 5'd0;
            end
            7'b1110011: begin
                d_rd = 5'd0;
                if (if_instr_i[19:7] != 13'd0)
                    d_illegal = 1'b1;
                else if (if_instr_i[31:20] == 12'h000 || if_instr_i[31:20] == 12'h001)
                    d_break = 1'b1;
                else if (if_instr_i[31:20] == 12'h302)
                    d_mret = 1'b1;
                else
                    d_illegal = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase

        if (if_instr_i[1:0] != 2'b11) d_illegal = 1'b1;

        if (d_illegal) begin
            d_break    = 1'b1;
            d_mret     = 1'b0;
            d_rd       = 5'd0;
            d_branch   = br_none;
            d_reg_jump = 1'b0;
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            irq_pending   <= 1'b0;
            id_valid_o    <= 1'b0;
            id_rd_idx_o   <= 5'd0;
            id_op_imm_o   <= 1'b0;
            id_imm_o      <= 32'd0;
            id_ra_value_o <= 32'd0;
            id_rb_value_o <= 32'd0;
            id_alu_op_o   <= 4'd0;
            id_a_signed_o <= 1'b0;
            id_b_signed_o <= 1'b0;
            id_break_o    <= 1'b0;
            id_pc_o       <= '0;
            id_next_pc_o  <= '0;
            id_irq_o      <= 1'b0;
            id_mret_o     <= 1'b0;
            id_branch_o   <= 3'd0;
            id_reg_jump_o <= 1'b0;
            id_illegal_o  <= 1'b0;
        end else if (branch_taken_i) begin
            // A flushed instruction must not consume the pending interrupt.
            id_valid_o  <= 1'b0;
            irq_pending <= irq_pending || irq_i;
        end else if (accept) begin
            irq_pending   <= 1'b0;
            id_valid_o    <= 1'b1;
            id_op_imm_o   <= d_op_imm;
            id_imm_o      <= d_imm;
            id_ra_value_o <= ra_value;
            id_rb_value_o <= rb_value;
            id_alu_op_o   <= d_alu_op;
            id_a_signed_o <= d_a_signed;
            id_b_signed_o <= d_b_signed;
            id_pc_o       <= if_pc_i;
            id_next_pc_o  <= if_next_pc_i;
            id_irq_o      <= irq_now;
            id_rd_idx_o   <= irq_now ? 5'd0 : d_rd;
            id_branch_o   <= irq_now ? br_none : d_branch;
            id_reg_jump_o <= irq_now ? 1'b0 : d_reg_jump;
            id_break_o    <= irq_now ? 1'b0 : d_break;
            id_mret_o     <= irq_now ? 1'b0 : d_mret;
            id_illegal_o  <= irq_now ? 1'b0 : d_illegal;
        end else begin
            irq_pending <= irq_pending || irq_i;
            if (!ex_stall_i) id_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iot_riscv_decode.sv
// tb/tb_iot_riscv_decode.sv - directed self-checking bench for iot_riscv_decode
module tb_iot_riscv_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_next_pc;
    logic        if_ready;
    logic        irq;
    logic        ex_stall;
    logic        branch_taken;
    logic [4:0]  rf_ra_idx;
    logic [4:0]  rf_rb_idx;
    logic [31:0] rf_ra_value;
    logic [31:0] rf_rb_value;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_value;
    logic        id_valid;
    logic [4:0]  id_rd_idx;
    logic        id_op_imm;
    logic [31:0] id_imm;
    logic [31:0] id_ra_value;
    logic [31:0] id_rb_value;
    logic [3:0]  id_alu_op;
    logic        id_a_signed;
    logic        id_b_signed;
    logic        id_break;
    logic [31:0] id_pc;
    logic [31:0] id_next_pc;
    logic        id_irq;
    logic        id_mret;
    logic [2:0]  id_branch;
    logic        id_reg_jump;
    logic        id_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iot_riscv_decode #(.pc_size_p(32)) dut (
        .main_clk_i(clk), .main_rst_i(rst),
        .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_i(if_pc),
        .if_next_pc_i(if_next_pc), .if_ready_o(if_ready),
        .irq_i(irq), .ex_stall_i(ex_stall), .branch_taken_i(branch_taken),
        .rf_ra_idx_o(rf_ra_idx), .rf_rb_idx_o(rf_rb_idx),
        .rf_ra_value_i(rf_ra_value), .rf_rb_value_i(rf_rb_value),
        .wb_en_i(wb_en), .wb_idx_i(wb_idx), .wb_value_i(wb_value),
        .id_valid_o(id_valid), .id_rd_idx_o(id_rd_idx), .id_op_imm_o(id_op_imm),
        .id_imm_o(id_imm), .id_ra_value_o(id_ra_value), .id_rb_value_o(id_rb_value),
        .id_alu_op_o(id_alu_op), .id_a_signed_o(id_a_signed), .id_b_signed_o(id_b_signed),
        .id_break_o(id_break), .id_pc_o(id_pc), .id_next_pc_o(id_next_pc),
        .id_irq_o(id_irq), .id_mret_o(id_mret), .id_branch_o(id_branch),
        .id_reg_jump_o(id_reg_jump), .id_illegal_o(id_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid   = 1'b1;
        if_instr   = instr;
        if_pc      = pc;
        if_next_pc = pc + 32'd4;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; if_next_pc = 32'd0;
        irq = 1'b0; ex_stall = 1'b0; branch_taken = 1'b0;
        rf_ra_value = 32'd0; rf_rb_value = 32'd0;
        wb_en = 1'b0; wb_idx = 5'd0; wb_value = 32'd0;
        step(); step();
        check("rst_valid", 32'(id_valid), 0);
        check("rst_ready", 32'(if_ready), 0);
        check("rst_rd", 32'(id_rd_idx), 0);
        check("rst_imm", id_imm, 0);
        check("rst_pc", id_pc, 0);
        check("rst_illegal", 32'(id_illegal), 0);
        rst = 1'b0;

        present(32'h00500093, 32'h100);
        step();
        check("addi_valid", 32'(id_valid), 1);
        check("addi_alu", 32'(id_alu_op), 0);
        check("addi_opimm", 32'(id_op_imm), 1);
        check("addi_imm", id_imm, 5);
        check("addi_rd", 32'(id_rd_idx), 1);
        check("addi_pc", id_pc, 32'h100);
        check("addi_npc", id_next_pc, 32'h104);
        check("addi_signed", 32'(id_a_signed), 1);

        present(32'hFE316EE3, 32'h104);
        rf_ra_value = 32'd7; rf_rb_value = 32'd9;
        #1;
        check("bltu_ra_idx", 32'(rf_ra_idx), 2);
        check("bltu_rb_idx", 32'(rf_rb_idx), 3);
        step();
        check("bltu_branch", 32'(id_branch), 3);
        check("bltu_asig", 32'(id_a_signed), 0);
        check("bltu_bsig", 32'(id_b_signed), 0);
        check("bltu_imm", id_imm, 32'hFFFFFFFC);
        check("bltu_ra", id_ra_value, 7);
        check("bltu_rb", id_rb_value, 9);
        check("bltu_rd", 32'(id_rd_idx), 0);
        check("bltu_opimm", 32'(id_op_imm), 0);

        present(32'h00A00113, 32'h108);
        rf_ra_value = 32'd0; rf_rb_value = 32'd0;
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", 32'(if_ready), 0);
            check("stall_valid", 32'(id_valid), 1);
            check("stall_imm", id_imm, 32'hFFFFFFFC);
            check("stall_branch", 32'(id_branch), 3);
        end
        ex_stall = 1'b0;
        step();
        check("release_imm", id_imm, 10);
        check("release_rd", 32'(id_rd_idx), 2);
        check("release_branch", 32'(id_branch), 0);
        check("release_pc", id_pc, 32'h108);

        present(32'h00500093, 32'h300);
        branch_taken = 1'b1;
        step();
        check("flush_valid", 32'(id_valid), 0);
        branch_taken = 1'b0;
        step();
        check("post_flush_valid", 32'(id_valid), 1);
        check("post_flush_pc", id_pc, 32'h300);
        if_valid = 1'b0;
        step();
        check("idle_valid", 32'(id_valid), 0);

        present(32'h00010233, 32'h400);
        wb_en = 1'b1; wb_idx = 5'd2; wb_value = 32'hDEADBEEF;
        step();
        check("bypass_ra", id_ra_value, 32'hDEADBEEF);
        check("bypass_rd", 32'(id_rd_idx), 4);
        present(32'h00000233, 32'h404);
        wb_idx = 5'd0;
        step();
        check("bypass_x0", id_ra_value, 0);
        present(32'h00010233, 32'h408);
        wb_idx = 5'd5; rf_ra_value = 32'h1234;
        step();
        check("no_bypass_ra", id_ra_value, 32'h1234);
        wb_en = 1'b0; rf_ra_value = 32'd0;

        if_valid = 1'b0;
        irq = 1'b1;
        step();
        irq = 1'b0;
        step();
        check("irq_wait_valid", 32'(id_valid), 0);
        present(32'h00000013, 32'h200);
        step();
        check("irq_flag", 32'(id_irq), 1);
        check("irq_rd", 32'(id_rd_idx), 0);
        check("irq_pc", id_pc, 32'h200);
        present(32'h00500093, 32'h204);
        step();
        check("irq_cleared", 32'(id_irq), 0);
        check("irq_cleared_rd", 32'(id_rd_idx), 1);

        present(32'h00500093, 32'h208);
        irq = 1'b1;
        step();
        irq = 1'b0;
        check("irq_same_flag", 32'(id_irq), 1);
        check("irq_same_rd", 32'(id_rd_idx), 0);
        step();
        check("irq_same_next", 32'(id_irq), 0);

        present(32'hFFFFFFFF, 32'h500);
        step();
        check("ill_flag", 32'(id_illegal), 1);
        check("ill_break", 32'(id_break), 1);
        check("ill_rd", 32'(id_rd_idx), 0);
        check("ill_branch", 32'(id_branch), 0);
        present(32'h00500090, 32'h504);
        step();
        check("ill_lowbits", 32'(id_illegal), 1);

        present(32'h027322B3, 32'h600);
        step();
        check("mulhsu_alu", 32'(id_alu_op), 10);
        check("mulhsu_asig", 32'(id_a_signed), 1);
        check("mulhsu_bsig", 32'(id_b_signed), 0);
        check("mulhsu_illegal", 32'(id_illegal), 0);
        present(32'h403100B3, 32'h604);
        step();
        check("sub_alu", 32'(id_alu_op), 1);
        present(32'h30200073, 32'h608);
        step();
        check("mret_flag", 32'(id_mret), 1);
        check("mret_rd", 32'(id_rd_idx), 0);
        present(32'h00100073, 32'h60C);
        step();
        check("ebreak_break", 32'(id_break), 1);
        check("ebreak_illegal", 32'(id_illegal), 0);
        present(32'h008100E7, 32'h610);
        step();
        check("jalr_branch", 32'(id_branch), 5);
        check("jalr_regjump", 32'(id_reg_jump), 1);
        check("jalr_alu", 32'(id_alu_op), 14);
        check("jalr_imm", id_imm, 8);
        check("jalr_rd", 32'(id_rd_idx), 1);
        present(32'h123451B7, 32'h614);
        step();
        check("lui_alu", 32'(id_alu_op), 13);
        check("lui_imm", id_imm, 32'h12345000);
        check("lui_opimm", 32'(id_op_imm), 1);
        if_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
